// File: rtl/round_ctrl.sv
// Round sequencer: button synchroniser/debouncer, press counter, round FSM and result latch.
// Define ROUND_WATCHDOG_EN to add a RUN-state watchdog that forces TIMEOUT and raises wd_err.
module round_ctrl #(
  parameter int DB_CYCLES = 200,
  parameter int HIT_W     = 8
`ifdef ROUND_WATCHDOG_EN
  ,
  parameter int WD_CYCLES = 210000
`endif
) (
  input  logic             clk_20k,
  input  logic             rst,
  input  logic             btn,
  input  logic             timer_done,
  output logic             timer_start,
  output logic [1:0]       state,
  output logic [HIT_W-1:0] hit_count,
  output logic [HIT_W-1:0] result,
  output logic             press
`ifdef ROUND_WATCHDOG_EN
  ,
  output logic             wd_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_TIMEOUT = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  localparam int               DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_db_level;
  logic            r_db_level_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;

  // The debounced level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_20k) begin
    if (rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_db_level   <= 1'b0;
      r_db_level_d <= 1'b0;
      r_db_cnt     <= '0;
      r_press      <= 1'b0;
    end else begin
      r_sync1      <= btn;
      r_sync2      <= r_sync1;
      r_db_level_d <= r_db_level;
      r_press      <= r_db_level & ~r_db_level_d;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  state_t           r_state;
  state_t           w_state_nx;
  logic [HIT_W-1:0] r_hits;
  logic [HIT_W-1:0] w_hits_nx;
  logic [HIT_W-1:0] r_result;
  logic [HIT_W-1:0] w_result_nx;
  logic             r_timer_start;

`ifdef ROUND_WATCHDOG_EN
  localparam int              WD_W    = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_cnt_nx;
  logic            r_wd_err;
  logic            w_wd_err_nx;
  logic            w_wd_hit;

  // Counter holds the number of RUN cycles already spent; the limit hits on the last allowed one.
  assign w_wd_hit = (r_wd_cnt == WD_LAST);
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_hits_nx   = r_hits;
    w_result_nx = r_result;
`ifdef ROUND_WATCHDOG_EN
    w_wd_cnt_nx = r_wd_cnt;
    w_wd_err_nx = r_wd_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_press) begin
          w_state_nx = S_RUN;
          w_hits_nx  = '0;
`ifdef ROUND_WATCHDOG_EN
          w_wd_cnt_nx = '0;
          w_wd_err_nx = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (r_press && (r_hits != HIT_MAX)) w_hits_nx = r_hits + 1'b1;
`ifdef ROUND_WATCHDOG_EN
        w_wd_cnt_nx = r_wd_cnt + 1'b1;
`endif
        if (timer_done) begin
          w_state_nx = S_TIMEOUT;
`ifdef ROUND_WATCHDOG_EN
        end else if (w_wd_hit) begin
          w_state_nx  = S_TIMEOUT;
          w_wd_err_nx = 1'b1;
`endif
        end
      end
      S_TIMEOUT: begin
        w_result_nx = r_hits;
        w_state_nx  = S_RESULT;
      end
      S_RESULT: begin
        if (r_press) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_20k) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_hits        <= '0;
      r_result      <= '0;
      r_timer_start <= 1'b0;
`ifdef ROUND_WATCHDOG_EN
      r_wd_cnt      <= '0;
      r_wd_err      <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nx;
      r_hits        <= w_hits_nx;
      r_result      <= w_result_nx;
      r_timer_start <= (w_state_nx == S_RUN);
`ifdef ROUND_WATCHDOG_EN
      r_wd_cnt      <= w_wd_cnt_nx;
      r_wd_err      <= w_wd_err_nx;
`endif
    end
  end

  assign state       = r_state;
  assign timer_start = r_timer_start;
  assign hit_count   = r_hits;
  assign result      = r_result;
  assign press       = r_press;
`ifdef ROUND_WATCHDOG_EN
  assign wd_err      = r_wd_err;
`endif

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: directed round scenarios plus random button/done/reset traffic,
// every cycle compared against a sample-window debounce model and a plain round model.
module tb_round_ctrl;

  localparam int DB   = 4;
  localparam int HW   = 4;
  localparam int HMAX = (1 << HW) - 1;
`ifdef ROUND_WATCHDOG_EN
  localparam int WD   = 50;
`endif

  logic          clk_20k = 1'b0;
  logic          rst;
  logic          btn;
  logic          timer_done;
  logic          timer_start;
  logic [1:0]    state;
  logic [HW-1:0] hit_count;
  logic [HW-1:0] result;
  logic          press;
`ifdef ROUND_WATCHDOG_EN
  logic          wd_err;
`endif

  always #25 clk_20k = ~clk_20k;

  round_ctrl #(
    .DB_CYCLES(DB),
    .HIT_W(HW)
`ifdef ROUND_WATCHDOG_EN
    ,
    .WD_CYCLES(WD)
`endif
  ) dut (
    .clk_20k(clk_20k),
    .rst(rst),
    .btn(btn),
    .timer_done(timer_done),
    .timer_start(timer_start),
    .state(state),
    .hit_count(hit_count),
    .result(result),
    .press(press)
`ifdef ROUND_WATCHDOG_EN
    ,
    .wd_err(wd_err)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: btn samples kept in a window; the game advanced by plain rules.
  bit hist[$];
  bit m_level;
  bit m_rose;
  bit m_press;
  int m_state;
  int m_hits;
  int m_result;
  int m_runc;
`ifdef ROUND_WATCHDOG_EN
  bit m_wd;
`endif

  task automatic model_step();
    bit old_press;
    bit all_diff;
    old_press = m_press;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < DB + 3; i++) hist.push_back(1'b0);
      m_level  = 1'b0;
      m_rose   = 1'b0;
      m_press  = 1'b0;
      m_state  = 0;
      m_hits   = 0;
      m_result = 0;
      m_runc   = 0;
`ifdef ROUND_WATCHDOG_EN
      m_wd     = 1'b0;
`endif
    end else begin
      hist.push_back(btn);
      if (hist.size() > DB + 3) void'(hist.pop_front());
      // Debouncer sees btn two edges late; it flips after DB consecutive disagreeing samples.
      all_diff = 1'b1;
      for (int k = 2; k <= DB + 1; k++)
        if (hist[hist.size() - 1 - k] == m_level) all_diff = 1'b0;
      m_press = m_rose;
      m_rose  = 1'b0;
      if (all_diff) begin
        m_level = !m_level;
        m_rose  = m_level;
      end
      case (m_state)
        0: if (old_press) begin
          m_state = 1;
          m_hits  = 0;
          m_runc  = 0;
`ifdef ROUND_WATCHDOG_EN
          m_wd    = 1'b0;
`endif
        end
        1: begin
          if (old_press && m_hits < HMAX) m_hits = m_hits + 1;
          m_runc = m_runc + 1;
          if (timer_done) m_state = 2;
`ifdef ROUND_WATCHDOG_EN
          else if (m_runc == WD) begin
            m_state = 2;
            m_wd    = 1'b1;
          end
`endif
        end
        2: begin
          m_result = m_hits;
          m_state  = 3;
        end
        default: if (old_press) m_state = 0;
      endcase
    end
  endtask

  task automatic tick(input bit b, input bit d, input bit r);
    btn        = b;
    timer_done = d;
    rst        = r;
    @(posedge clk_20k);
    model_step();
    @(negedge clk_20k);
    check_eq("state", state, m_state);
    check_eq("timer_start", timer_start, (m_state == 1) ? 1 : 0);
    check_eq("hit_count", hit_count, m_hits);
    check_eq("result", result, m_result);
    check_eq("press", press, m_press);
`ifdef ROUND_WATCHDOG_EN
    check_eq("wd_err", wd_err, m_wd);
`endif
  endtask

  task automatic press_btn();
    for (int i = 0; i < DB + 3; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DB + 3; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  int lat;
  int npress;
  int runs;
  bit seen;
  bit rb;
  bit rd;
  bit rr;
  int rlen;

  initial begin
    btn        = 1'b0;
    timer_done = 1'b0;
    rst        = 1'b1;

    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check_eq("rst_state", state, 0);
    check_eq("rst_hits", hit_count, 0);

`ifdef ROUND_WATCHDOG_EN
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (state == 2'd1) seen = 1'b1;
    end
    runs = seen ? 1 : 0;
    for (int i = 0; i < 200 && seen; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (state == 2'd1) runs++;
      else seen = 1'b0;
    end
    check_eq("wd_run_cycles", runs, WD);
    check_eq("wd_timeout", state, 2);
    check_eq("wd_err_set", wd_err, 1);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("wd_result", state, 3);
    for (int i = 0; i < DB + 3; i++) tick(1'b0, 1'b0, 1'b0);
    press_btn();
    check_eq("wd_back_idle", state, 0);
    check_eq("wd_err_sticky", wd_err, 1);
    press_btn();
    check_eq("wd_restart", state, 1);
    check_eq("wd_err_clear", wd_err, 0);
    tick(1'b0, 1'b0, 1'b1);
`else
    // Bouncy press: only the final stable high should produce a pulse.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    lat  = 99;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (press) begin
        lat  = i;
        seen = 1'b1;
      end
    end
    check_eq("press_latency", lat, 7);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("idle_to_run", state, 1);
    npress = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (press) npress++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (press) npress++;
    end
    check_eq("release_no_press", npress, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (press) npress++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (press) npress++;
    end
    check_eq("glitch_no_press", npress, 0);

    for (int i = 0; i < 5; i++) press_btn();
    check_eq("five_hits", hit_count, 5);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("done_timeout", state, 2);
    check_eq("done_start_low", timer_start, 0);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("done_result_state", state, 3);
    check_eq("done_result", result, 5);
    tick(1'b0, 1'b1, 1'b0);
    check_eq("linger_done_result", state, 3);

    press_btn();
    press_btn();
    for (int i = 0; i < 17; i++) press_btn();
    check_eq("sat_hits", hit_count, HMAX);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("sat_result", result, HMAX);

    press_btn();
    press_btn();
    press_btn();
    press_btn();
    for (int i = 0; i < DB + 3; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check_eq("coinc_state", state, 2);
    check_eq("coinc_hits", hit_count, 3);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("coinc_result", result, 3);
    for (int i = 0; i < DB + 3; i++) tick(1'b0, 1'b0, 1'b0);

    press_btn();
    check_eq("exit_idle", state, 0);
    check_eq("exit_hits_held", hit_count, 3);
    press_btn();
    check_eq("restart_run", state, 1);
    check_eq("restart_hits", hit_count, 0);
    tick(1'b0, 1'b0, 1'b1);
    check_eq("midrun_rst_state", state, 0);
    check_eq("midrun_rst_start", timer_start, 0);
`endif

    for (int n = 0; n < 400; n++) begin
      rb   = 1'($urandom_range(0, 1));
      rlen = $urandom_range(1, 12);
      for (int i = 0; i < rlen; i++) begin
        rd = ($urandom_range(0, 29) == 0);
        rr = ($urandom_range(0, 399) == 0);
        tick(rb, rd, rr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
- Round sequencer that drives the 10 s round timer: issues `timer_start`, consumes `timer_done`, and publishes the 2-bit game `state` that the timer and display logic read.
- Debounces the player button, counts presses during a round, and latches the final count for display.
- Sits between the button pad and the timer/seven-segment blocks in the 20 kHz domain.

Parameters:
- DB_CYCLES, 200, consecutive stable cycles required before the debounced button changes (10 ms at 20 kHz).
- HIT_W, 8, width of the press counter and the result register.
- WD_CYCLES, 210000, watchdog limit in RUN, in cycles (used only with the optional feature).

Ports:
- clk_20k  input  1  20 kHz system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  1  raw, asynchronous, bouncy player button.
- timer_done  input  1  round-timer expiry flag; may stay high for several cycles.
- timer_start  output  1  high while the round runs; low clears the timer.
- state  output  2  0=IDLE, 1=RUN, 2=TIMEOUT, 3=RESULT.
- hit_count  output  HIT_W  live press count for the current round.
- result  output  HIT_W  press count latched at round end.
- press  output  1  one-cycle pulse on each debounced rising edge of the button.

Behaviour:
- Reset: one clock, synchronous reset; `rst` sampled on the `clk_20k` rising edge, active-high.
- Values on reset:
  - `state`=0, `timer_start`=0, `hit_count`=0, `result`=0, `press`=0.
  - Synchroniser flops=0, debounced level=0, debounce counter=0.
- `rst` mid-round returns to IDLE on the next edge and clears `timer_start` there.
- Input conditioning:
  - 2-flop synchroniser on `btn`.
  - The debounced level takes the synchronised value once it has differed from the current level for DB_CYCLES consecutive cycles.
  - The counter clears whenever the synchronised value equals the level.
  - Debounce latency after the last bounce: 2 + DB_CYCLES cycles.
  - `press` is registered and high for exactly one cycle, on the cycle after the debounced level goes 0->1.
  - Releases generate nothing.
- FSM, one transition per cycle, all registered:
  - IDLE: `timer_start`=0. On `press` -> RUN; `hit_count` cleared to 0 on the same edge.
  - RUN: `timer_start`=1 from the first RUN cycle.
    - Each `press` increments `hit_count`, saturating at 2^HIT_W-1 (no wrap).
    - On `timer_done`=1 -> TIMEOUT.
    - If `press` and `timer_done` arrive in the same cycle, the press is counted and the transition is taken.
  - TIMEOUT: `timer_start`=0, so the timer clears.
    - `result` <= `hit_count`.
    - Unconditional -> RESULT next cycle; `press` in this cycle is ignored.
  - RESULT: `timer_start`=0; `result` held.
    - On `press` -> IDLE.
    - `hit_count` holds its value until the next round starts.
- `timer_done` is ignored in every state except RUN.
- The timer clears its done flag once `state`≠1, so a lingering done never re-triggers.
- `timer_start` is a decoded register: high iff `state`==1.
- Latency from the `timer_done` rising edge:
  - `state`=2 one edge later.
  - `timer_start` low on that same edge.
  - `result` valid one further edge later, with `state`=3.

Optional Feature:
- Macro: ROUND_WATCHDOG_EN.
- With the macro defined:
  - Adds output `wd_err` (1 bit, reset 0) and a cycle counter that clears on RUN entry and counts while in RUN.
  - If the counter reaches WD_CYCLES without `timer_done`, the FSM forces RUN -> TIMEOUT exactly as if done had arrived, and sets `wd_err`=1.
  - `wd_err` is sticky until `rst` or the next IDLE -> RUN transition.
  - If `timer_done` and the limit coincide, done wins and `wd_err` stays 0.
- Without the macro: no counter, no `wd_err` port; RUN is left only via `timer_done` or `rst`.

Test Plan (DB_CYCLES=4, HIT_W=4, timer modelled by the bench):
- Reset: drive `rst`=1 for 2 cycles with `btn` toggling -> `state`=0, `timer_start`=0, `hit_count`=0, `result`=0, `press`=0 throughout.
- Debounce:
  - `btn` bounces 1-0-1-0 on single cycles, then holds 1 -> exactly one `press`, 7 cycles after the final rising bounce.
  - `state` goes 0->1 on the edge after `press`.
  - A 3-cycle glitch yields no `press`.
- Normal round:
  - Start the round, then give 5 clean presses and pulse `timer_done` for 3 cycles -> `hit_count`=5, then `state`=2 for one cycle, then `state`=3 with `result`=5.
  - `timer_start` is high only while `state`=1.
- Saturation and coincidence:
  - 17 presses in RUN -> `hit_count` stops at 15.
  - A press in the same cycle as `timer_done` -> counted, and TIMEOUT still taken.
- Exit and reset mid-round:
  - In RESULT, a press -> IDLE; a further press -> RUN with `hit_count`=0.
  - `rst` pulsed while in RUN -> IDLE next edge and `timer_start`=0.
- Watchdog (ROUND_WATCHDOG_EN, WD_CYCLES=50):
  - No `timer_done` -> TIMEOUT after 50 RUN cycles with `wd_err`=1.
  - Next round start clears `wd_err`.
